z480_wb_arbiter: RTL and testbench

Writeback arbiter for the Z480 P7 core: collects completed uops from NUM_SRC execution units (integer ALU, branch, load/store, ...) over their `wb_valid`/`wb`/`wb_ready` handshake, picks one per cycle round-robin, and registers it into a single writeback stage. That stage drives the ROB completion and PRF write port and broadcasts a register wakeup. It is the consumer end of the execution-unit writeback interface.

---
 rtl/z480_pkg.sv | 23 ++
 rtl/z480_rr_pick.sv | 39 +++
 rtl/z480_wb_arbiter.sv | 110 +++++++++++
 tb/tb_z480_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z480_pkg.sv
// z480_pkg: shared Z480 core types and constants.
//   z480_wb_t        - writeback payload carried from execution units to ROB/PRF
//   Z480_WB_SRC_MAX  - maximum number of writeback sources an arbiter may take
//   z480_idx_w()     - index width helper for N-entry selectors (min 1 bit)
package z480_pkg;

    localparam int Z480_WB_SRC_MAX = 8;
    localparam int Z480_ROB_IDX_W  = 7;
    localparam int Z480_PRD_W      = 8;

    typedef struct packed {
        logic [Z480_ROB_IDX_W-1:0] rob_idx;
        logic                      prd_valid;
        logic [Z480_PRD_W-1:0]     prd;
        logic [63:0]               value;
        logic [31:0]               flags;
    } z480_wb_t;

    function automatic int z480_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/z480_rr_pick.sv
// z480_rr_pick: combinational round-robin picker.
//   N    - number of requesters
//   req  - request vector
//   ptr  - highest-priority position; search runs ptr, ptr+1, ... modulo N
//   gnt  - one-hot grant (zero when no request)
//   idx  - index of the granted requester (0 when no request)
//   any  - at least one request granted
module z480_rr_pick
    import z480_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = z480_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/z480_wb_arbiter.sv
// z480_wb_arbiter: round-robin writeback arbiter feeding a single registered
// writeback stage (ROB completion, PRF write, register wakeup).
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drops the registered entry and blocks grants
//   src_valid/src_wb    - per-source writeback request and payload
//   src_ready           - per-source grant, one-hot or zero (combinational)
//   out_valid/out_wb    - registered writeback to ROB/PRF
//   out_ready           - ROB/PRF accepts out_wb this cycle
//   wakeup_valid/_prd   - combinational wakeup when a writeback with a
//                         destination register is accepted downstream
//   perf_conflict_cnt   - saturating count of cycles where a valid source
//                         was left waiting; only with Z480_WB_ARB_PERF_EN
// NUM_SRC legal range is 2..Z480_WB_SRC_MAX.
module z480_wb_arbiter
    import z480_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  z480_wb_t [NUM_SRC-1:0]    src_wb,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      out_valid,
    output z480_wb_t                  out_wb,
    input  logic                      out_ready,
    output logic                      wakeup_valid,
    output logic [Z480_PRD_W-1:0]     wakeup_prd
`ifdef Z480_WB_ARB_PERF_EN
    ,
    output logic [31:0]               perf_conflict_cnt
`endif
);

    localparam int IW = z480_idx_w(NUM_SRC);

    logic               slot_free;
    logic               grant_en;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [IW-1:0]      rr_ptr;

    // The stage can take a new entry when empty or draining this cycle.
    assign slot_free = !out_valid || out_ready;
    assign grant_en  = slot_free && !flush;
    assign req       = grant_en ? src_valid : '0;

    z480_rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign src_ready = gnt;

    // ---- writeback stage register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_wb    <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_wb    <= src_wb[gnt_idx];
            rr_ptr    <= (gnt_idx == IW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign wakeup_valid = out_valid && out_ready && out_wb.prd_valid;
    assign wakeup_prd   = out_wb.prd;

`ifdef Z480_WB_ARB_PERF_EN
    function automatic int popcount(input logic [NUM_SRC-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_SRC; i++) n = n + int'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // A conflict is any valid source left ungranted in a non-flush cycle,
    // which includes sources stalled by a blocked output slot.
    logic conflict;
    assign conflict = !flush && (popcount(src_valid) > (gnt_any ? 1 : 0));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
        end else if (conflict) begin
            perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_z480_wb_arbiter.sv
module tb_z480_wb_arbiter;
    import z480_pkg::*;

    localparam int NS = 4;

    logic                 clk = 1'b0;
    logic                 rst, flush, out_ready;
    logic [NS-1:0]        src_valid;
    z480_wb_t [NS-1:0]    src_wb;
    logic [NS-1:0]        src_ready;
    logic                 out_valid;
    z480_wb_t             out_wb;
    logic                 wakeup_valid;
    logic [Z480_PRD_W-1:0] wakeup_prd;
`ifdef Z480_WB_ARB_PERF_EN
    logic [31:0]          perf_conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    z480_wb_arbiter #(.NUM_SRC(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_wb       (src_wb),
        .src_ready    (src_ready),
        .out_valid    (out_valid),
        .out_wb       (out_wb),
        .out_ready    (out_ready),
        .wakeup_valid (wakeup_valid),
        .wakeup_prd   (wakeup_prd)
`ifdef Z480_WB_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    // Reference model: one held writeback slot, a pointer, and a counter.
    logic     m_valid;
    z480_wb_t m_wb;
    int       m_ptr;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (flush || (m_valid && !out_ready)) return -1;
        for (int k = 0; k < NS; k++) begin
            if (src_valid[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
        end
        return -1;
    endfunction

    task automatic model_check();
        int g;
        logic [NS-1:0] er;
        g  = exp_grant();
        er = (g >= 0) ? NS'(1 << g) : '0;
        chk("src_ready", 128'(src_ready), 128'(er));
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("out_wb", 128'(out_wb), 128'(m_wb));
        chk("wakeup_valid", 128'(wakeup_valid), 128'(m_valid && out_ready && m_wb.prd_valid));
        chk("wakeup_prd", 128'(wakeup_prd), 128'(m_wb.prd));
`ifdef Z480_WB_ARB_PERF_EN
        chk("perf_cnt", 128'(perf_conflict_cnt), 128'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_wb    = '0;
        m_ptr   = 0;
        m_cnt   = '0;
    endtask

    task automatic model_advance();
        int g;
        if (rst) begin
            model_reset();
        end else begin
            g = exp_grant();
            if (!flush && ($countones(src_valid) > ((g >= 0) ? 1 : 0)) && m_cnt != 32'hFFFF_FFFF)
                m_cnt = m_cnt + 1;
            if (flush) begin
                m_valid = 1'b0;
            end else if (g >= 0) begin
                m_valid = 1'b1;
                m_wb    = src_wb[g];
                m_ptr   = (g + 1) % NS;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_next();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = '0;
        flush = 1'b0;
        at_neg();
        to_next();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NS-1:0] valid;
        logic          ready;
        logic          fl;
        logic [NS-1:0] exp_rdy;
        logic          exp_ov;
        logic [6:0]    exp_rob;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 7'd0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 7'd20};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 7'd9};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 7'd22};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 7'd23};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 7'd20};
        tbl[6]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 7'd0};
        tbl[7]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 7'd9};
        tbl[8]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 7'd9};
        tbl[9]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 7'd9};
        tbl[10] = '{4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1, 7'd9};
        tbl[11] = '{4'b0010, 1'b1, 1'b1, 4'b0000, 1'b1, 7'd22};
        tbl[12] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 7'd0};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 7'd9};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 7'd0};

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        src_valid = '0;
        src_wb = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state.
        at_neg();
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_src_ready", 128'(src_ready), 128'(0));
        to_next();

        // Single source 2 with rob_idx 5; then pointer must sit at 3.
        src_wb[2].rob_idx = 7'd5;
        src_valid = 4'b0100;
        at_neg();
        chk("single_grant", 128'(src_ready), 128'(4'b0100));
        to_next();
        src_valid = 4'b0000;
        at_neg();
        chk("single_out_valid", 128'(out_valid), 128'(1));
        chk("single_rob", 128'(out_wb.rob_idx), 128'(7'd5));
        to_next();
        src_valid = 4'b1001;
        at_neg();
        chk("ptr_after_2", 128'(src_ready), 128'(4'b1000));
        to_next();
        src_valid = 4'b0000;
        at_neg();
        to_next();

        // Wakeup with and without a destination register.
        src_wb[0].prd_valid = 1'b1;
        src_wb[0].prd = 8'd17;
        src_valid = 4'b0001;
        at_neg();
        to_next();
        src_valid = 4'b0000;
        at_neg();
        chk("wakeup_on", 128'(wakeup_valid), 128'(1));
        chk("wakeup_prd17", 128'(wakeup_prd), 128'(8'd17));
        to_next();
        src_wb[0].prd_valid = 1'b0;
        src_valid = 4'b0001;
        at_neg();
        to_next();
        src_valid = 4'b0000;
        at_neg();
        chk("wakeup_off", 128'(wakeup_valid), 128'(0));
        to_next();

        // Directed table: round robin, backpressure, flush.
        do_reset();
        for (int i = 0; i < NS; i++) begin
            src_wb[i] = '0;
            src_wb[i].rob_idx = (i == 1) ? 7'd9 : 7'(20 + i);
        end
        for (int r = 0; r < 15; r++) begin
            src_valid = tbl[r].valid;
            out_ready = tbl[r].ready;
            flush     = tbl[r].fl;
            at_neg();
            chk($sformatf("tbl%0d_ready", r), 128'(src_ready), 128'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d_ov", r), 128'(out_valid), 128'(tbl[r].exp_ov));
            if (tbl[r].exp_ov)
                chk($sformatf("tbl%0d_rob", r), 128'(out_wb.rob_idx), 128'(tbl[r].exp_rob));
            to_next();
        end
        flush = 1'b0;
        out_ready = 1'b1;

`ifdef Z480_WB_ARB_PERF_EN
        // Three sources valid for four cycles, then reset clears the counter.
        do_reset();
        src_valid = 4'b0111;
        repeat (4) begin
            at_neg();
            to_next();
        end
        src_valid = 4'b0000;
        at_neg();
        chk("perf_four", 128'(perf_conflict_cnt), 128'(32'd4));
        rst = 1'b1;
        to_next();
        rst = 1'b0;
        at_neg();
        chk("perf_reset", 128'(perf_conflict_cnt), 128'(0));
        chk("perf_reset_ov", 128'(out_valid), 128'(0));
        to_next();
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NS; i++) begin
                src_wb[i].rob_idx   = 7'($urandom);
                src_wb[i].prd_valid = ($urandom_range(0, 1) == 1);
                src_wb[i].prd       = 8'($urandom);
                src_wb[i].value     = {$urandom, $urandom};
                src_wb[i].flags     = $urandom;
            end
            src_valid = NS'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            at_neg();
            to_next();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
